// File: rtl/tc_bus_target.sv
// TC-bus memory target: combinational address acknowledge, in-order request
// queue, and a delayed completion engine that answers the queue head.
module tc_bus_target #(
    parameter int TC_AWIDTH   = 8,
    parameter int TC_DWIDTH   = 8,
    parameter int MAX_PENDING = 4,
    parameter int RESP_DELAY  = 2
) (
    input  logic                 clk_bus,
    input  logic                 rst_n,
    input  logic                 tc_req,
    input  logic                 tc_rnw,
    input  logic [TC_AWIDTH-1:0] tc_addr,
    input  logic [TC_DWIDTH-1:0] tc_wdata,
    input  logic                 resp_stall,
    output logic                 tc_aack,
    output logic                 tc_rack,
    output logic                 tc_wack,
    output logic [TC_DWIDTH-1:0] tc_rdata,
    output logic [2:0]           pending_cnt
);
    localparam int            PW    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int            QD    = 1 << PW;
    localparam int            MD    = 1 << TC_AWIDTH;
    localparam logic [2:0]    MP    = 3'(MAX_PENDING);
    localparam logic [2:0]    DLY   = 3'(RESP_DELAY);
    localparam logic [PW-1:0] PLAST = PW'(MAX_PENDING - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    logic [2:0]           r_dcnt;
    logic [2:0]           r_cnt;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic                 r_q_rnw   [QD];
    logic [TC_AWIDTH-1:0] r_q_addr  [QD];
    logic [TC_DWIDTH-1:0] r_q_wdata [QD];
    logic [TC_DWIDTH-1:0] r_mem     [MD];

    logic                 w_push;
    logic                 w_pop;
    logic                 w_arm;
    logic                 w_h_rnw;
    logic [TC_AWIDTH-1:0] w_h_addr;
    logic [TC_DWIDTH-1:0] w_h_wdata;

    // Occupancy is compared before any same-cycle pop, so a completing head
    // never frees its slot early.
    assign tc_aack   = tc_req && (r_cnt < MP);
    assign w_push    = tc_aack;
    assign w_pop     = (r_state == S_RESP);
    assign w_h_rnw   = r_q_rnw[r_rptr];
    assign w_h_addr  = r_q_addr[r_rptr];
    assign w_h_wdata = r_q_wdata[r_rptr];

    // A new head is armed either by a push into an empty queue or by a pop
    // that leaves something behind (an entry already queued, or one pushed now).
    assign w_arm = ((r_state == S_IDLE) && w_push) ||
                   (w_pop && ((r_cnt > 3'd1) || w_push));

    assign tc_rack     = w_pop && w_h_rnw;
    assign tc_wack     = w_pop && !w_h_rnw;
    assign tc_rdata    = tc_rack ? r_mem[w_h_addr] : '0;
    assign pending_cnt = r_cnt;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
        end else if (w_arm) begin
            r_dcnt  <= DLY;
            r_state <= (RESP_DELAY == 0 && !resp_stall) ? S_RESP : S_WAIT;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (!resp_stall) begin
                        if (r_dcnt <= 3'd1) begin
                            r_dcnt  <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_dcnt <= r_dcnt - 3'd1;
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == PLAST) ? '0 : r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= (r_rptr == PLAST) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 3'd1;
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_bus) begin
        if (w_push) begin
            r_q_rnw[r_wptr]   <= tc_rnw;
            r_q_addr[r_wptr]  <= tc_addr;
            r_q_wdata[r_wptr] <= tc_wdata;
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MD; i++)
                r_mem[i] <= '0;
        end else if (tc_wack) begin
            r_mem[w_h_addr] <= w_h_wdata;
        end
    end
endmodule
